// File: rtl/j_uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity rule common to the transmitter and the receiver.
package j_uart_pkg;

    // Oversample ticks per bit and the half-bit point used to qualify a start.
    localparam int UART_OVS      = 16;
    localparam int UART_OVS_HALF = UART_OVS / 2;

    // Widest data field the parity helper accepts; callers zero-extend.
    localparam int PAR_MAX_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRKWAIT
    } uart_state_e;

    // Parity bit a frame must carry: even=1 makes the total count of ones
    // even, even=0 makes it odd. Zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [PAR_MAX_BITS-1:0] data,
                                        input logic                    even);
        return (^data) ^ ~even;
    endfunction

endpackage

// File: rtl/j_rxsync.sv
// Receive-line conditioning: optional polarity inversion followed by a
// two-flop synchroniser. Both flops reset to mark so a reset never looks
// like a start edge.
module j_rxsync (
    input  logic sys_clk,
    input  logic resetl,
    input  logic serin,
    input  logic rxpol,
    output logic line
);

    logic meta;

    // Two-stage synchroniser on the polarity-corrected serial input.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments let both stages sample the old
        // values on the same edge; blocking here would collapse the chain
        // into a single flop.
        if (!resetl) begin
            meta <= 1'b1;
            line <= 1'b1;
        end else begin
            meta <= serin ^ rxpol;
            line <= meta;
        end
    end

endmodule

// File: rtl/j_rxer.sv
// UART receiver: start-bit qualification at mid-bit, data/parity/stop
// sampling every OVS strobes, and a single-character receive buffer with
// full, parity, framing, overrun and break flags cleared by a host read.
module j_rxer
    import j_uart_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int OVS   = UART_OVS
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             serin,
    input  logic             bx16,
    input  logic             paren,
    input  logic             even,
    input  logic             rxpol,
    input  logic             u2drd,
    output logic [DBITS-1:0] dout,
    output logic             rbf,
    output logic             perr,
    output logic             ferr,
    output logic             oerr,
    output logic             rxbrk
);

    localparam int TW = $clog2(OVS);
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

    logic line;

    uart_state_e      state, state_d;
    logic [TW-1:0]    tick, tick_d;
    logic [BW-1:0]    bitn, bitn_d;
    logic [DBITS-1:0] shreg, shreg_d;
    logic             perr_n, perr_n_d;
    logic             par_bit, par_bit_d;

    logic             frame_done;
    logic             stop_bad;
    logic             brk_n;

    j_rxsync u_sync (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .serin   (serin),
        .rxpol   (rxpol),
        .line    (line)
    );

    // Frame state register: FSM, oversample tick, bit index, shift register.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state   <= IDLE;
            tick    <= '0;
            bitn    <= '0;
            shreg   <= '0;
            perr_n  <= 1'b0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            bitn    <= bitn_d;
            shreg   <= shreg_d;
            perr_n  <= perr_n_d;
            par_bit <= par_bit_d;
        end
    end

    // Next-state logic; everything advances only on strobe cycles.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned and infers a latch.
        state_d    = state;
        tick_d     = tick;
        bitn_d     = bitn;
        shreg_d    = shreg;
        perr_n_d   = perr_n;
        par_bit_d  = par_bit;
        frame_done = 1'b0;
        stop_bad   = 1'b0;

        if (bx16) begin
            unique case (state)
                IDLE: begin
                    if (!line) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick == TICK_HALF) begin
                        if (line) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            tick_d    = '0;
                            bitn_d    = '0;
                            perr_n_d  = 1'b0;
                            par_bit_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end
                DATA: begin
                    if (tick == TICK_LAST) begin
                        tick_d  = '0;
                        // Shift in at the top so the first bit ends at bit 0.
                        shreg_d = {line, shreg[DBITS-1:1]};
                        if (bitn == BIT_LAST) begin
                            state_d = paren ? PARITY : STOP;
                        end else begin
                            bitn_d = bitn + BW'(1);
                        end
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick == TICK_LAST) begin
                        tick_d    = '0;
                        par_bit_d = line;
                        perr_n_d  = line != parity_bit(PAR_MAX_BITS'(shreg), even);
                        state_d   = STOP;
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end
                STOP: begin
                    if (tick == TICK_LAST) begin
                        tick_d     = '0;
                        frame_done = 1'b1;
                        stop_bad   = !line;
                        // A good stop returns at mid-bit so a back-to-back
                        // start edge half a bit later is still caught.
                        state_d    = line ? IDLE : BRKWAIT;
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end
                BRKWAIT: begin
                    if (line) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A break is a framing error on an all-zero frame, parity bit included.
    assign brk_n = stop_bad && (shreg == '0) && (!paren || !par_bit);

    // Receive buffer and status flags; a completing frame beats a host read.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            dout  <= '0;
            rbf   <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            oerr  <= 1'b0;
            rxbrk <= 1'b0;
        end else if (frame_done) begin
            dout  <= shreg;
            rbf   <= 1'b1;
            perr  <= perr_n;
            ferr  <= stop_bad;
            rxbrk <= brk_n;
            oerr  <= rbf && !u2drd;
        end else if (u2drd) begin
            rbf   <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            oerr  <= 1'b0;
            rxbrk <= 1'b0;
        end
    end

endmodule

// File: tb/tb_j_rxer.sv
// Self-checking bench for j_rxer. Frames are sent as whole bit cells of 16
// strobes; each frame's completion edge and resulting buffer contents are
// derived from the frame itself and the latency rule, queued, and a
// per-cycle compare checks every output against the resulting buffer model.
module tb_j_rxer;

    localparam int DBITS = 8;
    localparam int CELL  = 64;  // 16 strobes x 4 clocks per bit cell

    logic       sys_clk = 1'b0;
    logic       resetl  = 1'b0;
    logic       serin   = 1'b1;
    logic       bx16    = 1'b0;
    logic       paren   = 1'b0;
    logic       even    = 1'b0;
    logic       rxpol   = 1'b0;
    logic       u2drd   = 1'b0;
    logic [7:0] dout;
    logic       rbf, perr, ferr, oerr, rxbrk;

    j_rxer #(.DBITS(DBITS), .OVS(16)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .serin   (serin),
        .bx16    (bx16),
        .paren   (paren),
        .even    (even),
        .rxpol   (rxpol),
        .u2drd   (u2drd),
        .dout    (dout),
        .rbf     (rbf),
        .perr    (perr),
        .ferr    (ferr),
        .oerr    (oerr),
        .rxbrk   (rxbrk)
    );

    always #5 sys_clk = ~sys_clk;

    int ecount  = 0;   // rising edges seen so far
    int n_checks = 0;
    int n_fail   = 0;
    int rd_edge  = -1; // edge at which a scheduled host read lands
    bit rd_rand  = 1'b0;
    bit chk_en   = 1'b0;

    typedef struct {
        int         edge_n;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rec_t;

    rec_t pend[$];

    logic [7:0] m_dout = '0;
    logic       m_rbf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
    logic       m_oerr = 1'b0, m_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Buffer model: frames land at their computed edge, reads clear status.
    always @(posedge sys_clk) begin
        ecount = ecount + 1;
        if (!resetl) begin
            m_dout = '0; m_rbf = 0; m_perr = 0; m_ferr = 0; m_oerr = 0; m_brk = 0;
            pend.delete();
        end else if (pend.size() > 0 && pend[0].edge_n == ecount) begin
            m_oerr = m_rbf && !u2drd;
            m_rbf  = 1'b1;
            m_dout = pend[0].data;
            m_perr = pend[0].perr;
            m_ferr = pend[0].ferr;
            m_brk  = pend[0].brk;
            void'(pend.pop_front());
        end else if (u2drd) begin
            m_rbf = 0; m_perr = 0; m_ferr = 0; m_oerr = 0; m_brk = 0;
        end
    end

    // Strobe every fourth clock and host-read driver.
    always @(negedge sys_clk) begin
        bx16  = ((ecount + 1) % 4 == 0);
        u2drd = (ecount + 1 == rd_edge) || (rd_rand && $urandom_range(0, 99) == 0);
    end

    // Per-cycle compare against the buffer model.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("dout",  32'(dout),  32'(m_dout));
            check("rbf",   32'(rbf),   32'(m_rbf));
            check("perr",  32'(perr),  32'(m_perr));
            check("ferr",  32'(ferr),  32'(m_ferr));
            check("oerr",  32'(oerr),  32'(m_oerr));
            check("rxbrk", 32'(rxbrk), 32'(m_brk));
        end
    end

    task automatic align();
        while (ecount % 4 != 0) @(negedge sys_clk);
    endtask

    task automatic wait_until(input int e);
        while (ecount < e) @(negedge sys_clk);
    endtask

    task automatic drive_cell(input logic b);
        serin = b ^ rxpol;
        repeat (CELL) @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        align();
        repeat (n) drive_cell(1'b1);
    endtask

    task automatic rd_pulse();
        rd_edge = ecount + 2;
        repeat (2) @(negedge sys_clk);
    endtask

    // Edge on which the stop bit is sampled for a start driven at edge s:
    // detection on the first strobe past the synchroniser, then
    // (1 + DBITS + paren)*16 + 8 strobes.
    function automatic int done_edge(input int s);
        return s + 4 + 4 * ((1 + DBITS + int'(paren)) * 16 + 8);
    endfunction

    task automatic send_frame(input logic [7:0] data, input bit pflip,
                              input bit stop_v, input int abort_after);
        int   s;
        logic pb;
        bit   cells[$];
        rec_t r;
        align();
        s  = ecount;
        pb = (^data) ^ ~even ^ pflip;
        r.edge_n = done_edge(s);
        r.data   = data;
        r.perr   = paren && pflip;
        r.ferr   = !stop_v;
        r.brk    = !stop_v && data == 8'h00 && (!paren || pb == 1'b0);
        pend.push_back(r);
        cells.push_back(1'b0);
        for (int i = 0; i < DBITS; i++) cells.push_back(data[i]);
        if (paren) cells.push_back(pb);
        cells.push_back(stop_v);
        foreach (cells[i]) begin
            if (abort_after > 0 && i == abort_after) return;
            drive_cell(cells[i]);
        end
    endtask

    task automatic send_break(input int n);
        rec_t r;
        align();
        r.edge_n = done_edge(ecount);
        r.data   = 8'h00;
        r.perr   = paren && !even;  // odd parity of zero data wants a 1
        r.ferr   = 1'b1;
        r.brk    = 1'b1;
        pend.push_back(r);
        repeat (n) drive_cell(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int s;
        logic [7:0] d;
        bit st;

        repeat (3) @(negedge sys_clk);
        check("reset_dout", 32'(dout), 0);
        check("reset_rbf",  32'(rbf),  0);
        check("reset_flags", 32'({perr, ferr, oerr, rxbrk}), 0);
        chk_en = 1'b1;
        resetl = 1'b1;
        idle(1);

        // 0xA5, no parity: exact completion edge pinned by hand (152*4 + 4).
        align();
        s = ecount;
        fork
            send_frame(8'hA5, 0, 1, 0);
            begin
                wait_until(s + 611);
                check("a5_rbf_early", 32'(rbf), 0);
                wait_until(s + 612);
                check("a5_rbf", 32'(rbf), 1);
                check("a5_dout", 32'(dout), 32'h A5);
                check("a5_flags", 32'({perr, ferr, oerr, rxbrk}), 0);
            end
        join
        rd_pulse();
        check("a5_read_rbf", 32'(rbf), 0);
        check("a5_read_dout", 32'(dout), 32'h A5);

        // 0x3C has four ones: even parity bit is 0.
        idle(1);
        paren = 1'b1;
        even  = 1'b1;
        send_frame(8'h3C, 0, 1, 0);
        check("3c_perr_ok", 32'(perr), 0);
        check("3c_dout", 32'(dout), 32'h 3C);
        rd_pulse();
        send_frame(8'h3C, 1, 1, 0);
        check("3c_perr_bad", 32'(perr), 1);
        rd_pulse();
        check("3c_perr_clr", 32'(perr), 0);
        paren = 1'b0;

        // Five-strobe glitch is a false start.
        idle(1);
        serin = 1'b0;
        repeat (20) @(negedge sys_clk);
        idle(2);
        check("glitch_rbf", 32'(rbf), 0);
        send_frame(8'h81, 0, 1, 0);
        check("81_dout", 32'(dout), 32'h 81);
        rd_pulse();

        // Overrun, then a read landing exactly on the completion cycle.
        send_frame(8'h11, 0, 1, 0);
        send_frame(8'h22, 0, 1, 0);
        check("ovr_dout", 32'(dout), 32'h 22);
        check("ovr_oerr", 32'(oerr), 1);
        rd_pulse();
        send_frame(8'h11, 0, 1, 0);
        align();
        rd_edge = done_edge(ecount);
        send_frame(8'h22, 0, 1, 0);
        check("race_rbf", 32'(rbf), 1);
        check("race_oerr", 32'(oerr), 0);
        check("race_dout", 32'(dout), 32'h 22);
        rd_pulse();

        // Break: 20 bit times low.
        send_break(20);
        check("brk_ferr", 32'(ferr), 1);
        check("brk_rxbrk", 32'(rxbrk), 1);
        check("brk_dout", 32'(dout), 0);
        idle(2);
        rd_pulse();
        send_frame(8'h55, 0, 1, 0);
        check("55_dout", 32'(dout), 32'h 55);
        check("55_flags", 32'({perr, ferr, oerr, rxbrk}), 0);
        rd_pulse();

        // Inverted line, then a reset in the middle of the data bits.
        align();
        rxpol = 1'b1;
        serin = 1'b0;
        idle(1);
        send_frame(8'h0F, 0, 1, 0);
        check("pol_dout", 32'(dout), 32'h 0F);
        send_frame(8'h99, 0, 1, 4);
        serin  = 1'b0;
        resetl = 1'b0;
        @(negedge sys_clk);
        check("rst_dout", 32'(dout), 0);
        check("rst_status", 32'({rbf, perr, ferr, oerr, rxbrk}), 0);
        resetl = 1'b1;
        idle(1);
        send_frame(8'h6B, 0, 1, 0);
        check("6b_dout", 32'(dout), 32'h 6B);
        rd_pulse();
        align();
        rxpol = 1'b0;
        serin = 1'b1;
        idle(1);

        // Random frames with random settings, errors and host reads.
        rd_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            align();
            paren = 1'($urandom_range(0, 1));
            even  = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            st    = ($urandom_range(0, 7) != 0);
            send_frame(d, ($urandom_range(0, 7) == 0), st, 0);
            idle(st ? $urandom_range(0, 2) : $urandom_range(1, 3));
        end
        rd_rand = 1'b0;
        idle(2);

        check("pending_drained", 32'(pend.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j_rxer.md
Name: j_rxer

Overview:
- UART receive stage; the serial-side peer of the transmitter. Consumes the serial line and produces 8-bit characters plus status for the UART register block.
- Oversamples the line using the 16x baud strobe shared with the transmitter.
- Holds one received character in a buffer with full, parity, framing, overrun and break flags; the host read strobe clears the buffer.

Parameters:
- DBITS, 8, number of data bits per frame; LSB is received first.
- OVS, 16, oversample ticks per bit; the start bit is qualified at tick OVS/2.

Ports:
- sys_clk  in  1  sole clock; every register is clocked on its rising edge.
- resetl  in  1  synchronous, active-low reset.
- serin  in  1  asynchronous serial input.
- bx16  in  1  16x baud strobe; one sys_clk cycle wide.
- paren  in  1  1 = a parity bit follows the data bits.
- even  in  1  1 = even parity, 0 = odd parity.
- rxpol  in  1  1 = invert serin before any use.
- u2drd  in  1  host read strobe; one cycle wide.
- dout  out  DBITS  receive buffer.
- rbf  out  1  receive buffer full.
- perr  out  1  parity error.
- ferr  out  1  framing error.
- oerr  out  1  overrun error.
- rxbrk  out  1  break received.

Behaviour:
- Reset: synchronous, active-low, on sys_clk. When resetl is sampled low:
  - dout=0; rbf, perr, ferr, oerr, rxbrk = 0.
  - FSM goes to IDLE; tick and bit counters = 0.
  - Synchroniser flops = 1 (mark).
  - Reset mid-frame abandons the frame; no flag is produced for it.
- Input path: rx = serin XOR rxpol, passed through a 2-flop synchroniser. Every reference to "line" below means the synchronised rx.
- All FSM and counter activity advances only on cycles with bx16=1. Exception: the flag and buffer logic reacts to u2drd on any cycle.
- IDLE:
  - Line=0 on a bx16 cycle: go to START with tick=0.
- START:
  - At tick OVS/2-1 (the 8th strobe), sample the line.
  - Sample 1: false start, return to IDLE.
  - Sample 0: go to DATA with tick=0 and bit=0.
- DATA:
  - On every 16th strobe, shift the line sample into the shift register MSB-first, so the final register is LSB-first aligned.
  - After DBITS samples, go to PARITY if paren=1, otherwise to STOP.
- PARITY:
  - Sample on the 16th strobe.
  - Expected bit = (XOR of data) XOR ~even.
  - Mismatch sets perr_n; then go to STOP.
- STOP:
  - Sample on the 16th strobe, i.e. at mid-stop-bit, then complete the frame (below).
  - Stop=1: go to IDLE immediately, so a back-to-back start edge can be caught half a bit later.
  - Stop=0: ferr_n=1. If the data is all zero and the parity bit (when enabled) is 0, also set rxbrk_n. Go to BRKWAIT.
- BRKWAIT:
  - Stay until the line is 1 on a bx16 cycle, then go to IDLE.
- Frame completion: happens in the same sys_clk cycle as the stop sample; the register outputs update on the following edge.
  - dout <= shift register; perr <= perr_n; ferr <= ferr_n; rxbrk <= rxbrk_n; rbf <= 1.
  - If rbf=1 and u2drd=0 in that cycle: oerr <= 1, and the buffer and flags are overwritten by the new frame.
  - If u2drd=1 in that same cycle: the load wins, rbf stays 1, and oerr is not set.
- u2drd with no completion: clears rbf, perr, ferr, oerr and rxbrk on the next edge; dout holds its value.
- Latency: from the synchronised falling edge to rbf high is (1 + DBITS + paren)*16 + 8 strobes, plus 1 sys_clk.
- paren, even and rxpol must be static while a frame is in flight. A change mid-frame leaves that frame undefined but the FSM always recovers by the next IDLE.

Decomposition:
- Shared package j_uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - OVS and OVS/2 constants.
  - Parity function, used by both the transmitter and this receiver.
- Sub-module j_rxsync: polarity XOR plus the 2-flop synchroniser, reset to 1.
- The FSM, counters and buffer stay in j_rxer.

Test Plan:
- Frame 0xA5, paren=0, bx16 every 4 clocks → dout=0xA5 and rbf=1 exactly 152 strobes + 1 clk after the edge (+ synchroniser delay); all error flags 0; u2drd then clears rbf.
- 0x3C with paren=1, even=1, parity bit 0 → perr=0. Same frame with parity bit 1 → perr=1. u2drd clears perr.
- Low glitch lasting 5 strobes → FSM back in IDLE, rbf stays 0. A valid 0x81 sent next → dout=0x81.
- Frames 0x11 then 0x22 with no read → dout=0x22, oerr=1. Repeat with u2drd pulsed in the exact completion cycle of 0x22 → rbf=1, oerr=0.
- Line held 0 for 20 bit times → ferr=1, rxbrk=1, dout=0x00. No new frame until the line returns to 1; a subsequent 0x55 is received cleanly.
- rxpol=1 with an inverted 0x0F stream → dout=0x0F. resetl pulsed low mid-DATA → all outputs 0 on the next edge, and the next frame is received correctly.
